// File: rtl/icnd2026_pkg.sv
// Shared constants and state encoding for the ICND2026 BCM scanner and its on-time timer.
package icnd2026_pkg;
   localparam int PIXELS     = 256;
   localparam int BITS       = 8;
   localparam int BASE_TICKS = 32;
   localparam int LAT_CYCLES = 2;

   localparam int ADDR_W    = (PIXELS > 1) ? $clog2(PIXELS) : 1;
   localparam int SHOW_W    = $clog2(BASE_TICKS) + BITS;
   localparam int CNT_W     = (SHOW_W < 16) ? 16 : SHOW_W;
   localparam int PLANE_LSB = 16 - BITS;
   localparam int LAT_W     = 4;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_FETCH = 3'd1;
   localparam state_t ST_SHIFT = 3'd2;
   localparam state_t ST_LATCH = 3'd3;
   localparam state_t ST_SHOW  = 3'd4;

   function automatic logic [CNT_W-1:0] plane_weight(input logic [2:0] plane);
      return CNT_W'(BASE_TICKS) << plane;
   endfunction
endpackage

// File: rtl/icnd2026_bcm_scanner_bcm_on_timer.sv
// BCM on-time timer: holds OE low for the plane on-time and pulses done on the last SHOW cycle.
// With ICND2026_GLOBAL_DIM_EN the on-time is scaled by dim while the window length stays fixed.
module bcm_on_timer
   import icnd2026_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] weight,
`ifdef ICND2026_GLOBAL_DIM_EN
   input  logic [7:0]       dim,
`endif
   output logic             oe,
   output logic             done
);
   logic [CNT_W-1:0] win_cnt;

`ifdef ICND2026_GLOBAL_DIM_EN
   logic [CNT_W+8:0] scaled;
   logic [CNT_W-1:0] on_raw;
   logic [CNT_W-1:0] on_time;
   logic [CNT_W-1:0] on_cnt;

   // dim+1 of 256 never exceeds the weight, so the shifted product always fits CNT_W bits
   assign scaled  = (CNT_W+9)'(weight) * (CNT_W+9)'({1'b0, dim} + 9'd1);
   assign on_raw  = CNT_W'(scaled >> 8);
   assign on_time = (on_raw == '0) ? CNT_W'(1) : on_raw;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         win_cnt <= '0;
         on_cnt  <= '0;
         oe      <= 1'b1;
      end else if (load) begin
         win_cnt <= weight;
         on_cnt  <= on_time;
         oe      <= 1'b0;
      end else begin
         if (win_cnt != '0) win_cnt <= win_cnt - CNT_W'(1);
         if (on_cnt != '0) begin
            on_cnt <= on_cnt - CNT_W'(1);
            if (on_cnt == CNT_W'(1)) oe <= 1'b1;
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         win_cnt <= '0;
         oe      <= 1'b1;
      end else if (load) begin
         win_cnt <= weight;
         oe      <= 1'b0;
      end else if (win_cnt != '0) begin
         win_cnt <= win_cnt - CNT_W'(1);
         if (win_cnt == CNT_W'(1)) oe <= 1'b1;
      end
   end
`endif

   assign done = (win_cnt == CNT_W'(1));
endmodule

// File: rtl/icnd2026_bcm_scanner.sv
// ICND2026 BCM scanner: streams bit-planes from two pixel RAMs to two driver chains on a shared
// CLK/LAT/OE bus. Define ICND2026_GLOBAL_DIM_EN to add the i_dim global dimmer port.
//
// state | meaning
// IDLE  | blanked, waiting for i_enable
// FETCH | reload read address with the last channel
// SHIFT | two cycles per pixel: phase0 data out, phase1 CLK high
// LATCH | LAT high for LAT_CYCLES, CLK low, data held
// SHOW  | OE low for the plane weight, then next plane
module icnd2026_bcm_scanner
   import icnd2026_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_enable,
`ifdef ICND2026_GLOBAL_DIM_EN
   input  logic [7:0]  i_dim,
`endif
   output logic [7:0]  o_raddr,
   input  logic [15:0] i_rdata_1,
   input  logic [15:0] i_rdata_2,
   output logic        o_led_clk,
   output logic        o_led_lat,
   output logic        o_led_oe,
   output logic        o_led_red1,
   output logic        o_led_red2,
   output logic        o_frame_strobe,
   output logic [2:0]  o_plane
);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PIXELS - 1);

   state_t            state_q, state_d;
   logic              phase_q, phase_d;
   logic              last_q, last_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic [2:0]        plane_q, plane_d;
   logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
   logic              red1_q, red1_d, red2_q, red2_d;
   logic              strobe_q, strobe_d;
   logic              led_clk_q, led_lat_q;
   logic              load, done;
   logic [3:0]        bit_idx;
   logic              shift_data;

   assign bit_idx    = 4'(PLANE_LSB) + {1'b0, plane_q};
   assign shift_data = (state_q == ST_SHIFT) && !phase_q;

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      last_d    = last_q;
      raddr_d   = raddr_q;
      plane_d   = plane_q;
      lat_cnt_d = lat_cnt_q;
      red1_d    = red1_q;
      red2_d    = red2_q;
      strobe_d  = 1'b0;
      load      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_enable) begin
               state_d = ST_FETCH;
               plane_d = '0;
               raddr_d = ADDR_LAST;
            end
         end
         ST_FETCH: begin
            state_d = ST_SHIFT;
            phase_d = 1'b0;
            last_d  = 1'b0;
         end
         ST_SHIFT: begin
            if (!phase_q) begin
               phase_d = 1'b1;
               red1_d  = i_rdata_1[bit_idx];
               red2_d  = i_rdata_2[bit_idx];
               if (raddr_q == '0) last_d = 1'b1;
               else raddr_d = raddr_q - ADDR_W'(1);
            end else begin
               phase_d = 1'b0;
               if (last_q) begin
                  state_d   = ST_LATCH;
                  lat_cnt_d = LAT_W'(LAT_CYCLES - 1);
               end
            end
         end
         ST_LATCH: begin
            if (lat_cnt_q == '0) begin
               state_d = ST_SHOW;
               load    = 1'b1;
            end else begin
               lat_cnt_d = lat_cnt_q - LAT_W'(1);
            end
         end
         ST_SHOW: begin
            if (done) begin
               if (plane_q == 3'(BITS - 1)) begin
                  plane_d  = '0;
                  strobe_d = 1'b1;
               end else begin
                  plane_d = plane_q + 3'd1;
               end
               if (i_enable) begin
                  state_d = ST_FETCH;
                  raddr_d = ADDR_LAST;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Pin registers are driven from next-state so CLK/LAT line up exactly with the FSM states
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         phase_q   <= 1'b0;
         last_q    <= 1'b0;
         raddr_q   <= '0;
         plane_q   <= '0;
         lat_cnt_q <= '0;
         red1_q    <= 1'b0;
         red2_q    <= 1'b0;
         strobe_q  <= 1'b0;
         led_clk_q <= 1'b0;
         led_lat_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         last_q    <= last_d;
         raddr_q   <= raddr_d;
         plane_q   <= plane_d;
         lat_cnt_q <= lat_cnt_d;
         red1_q    <= red1_d;
         red2_q    <= red2_d;
         strobe_q  <= strobe_d;
         led_clk_q <= (state_d == ST_SHIFT) && phase_d;
         led_lat_q <= (state_d == ST_LATCH);
      end
   end

   bcm_on_timer u_on_timer (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .load   (load),
      .weight (plane_weight(plane_q)),
`ifdef ICND2026_GLOBAL_DIM_EN
      .dim    (i_dim),
`endif
      .oe     (o_led_oe),
      .done   (done)
   );

   // RAM data arrives in phase0, so the data pins pass it straight through then and hold it after
   assign o_led_red1     = shift_data ? i_rdata_1[bit_idx] : red1_q;
   assign o_led_red2     = shift_data ? i_rdata_2[bit_idx] : red2_q;
   assign o_raddr        = 8'(raddr_q);
   assign o_led_clk      = led_clk_q;
   assign o_led_lat      = led_lat_q;
   assign o_frame_strobe = strobe_q;
   assign o_plane        = plane_q;
endmodule

// File: tb/tb_icnd2026_bcm_scanner.sv
// Directed bench for icnd2026_bcm_scanner; ICND2026_GLOBAL_DIM_EN adds the dimmer scenario.
module tb_icnd2026_bcm_scanner;
   localparam int LIMIT = 20000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [7:0]  raddr;
   logic [15:0] rdata_1, rdata_2;
   logic        led_clk, led_lat, led_oe, red1, red2, frame_strobe;
   logic [2:0]  plane;
`ifdef ICND2026_GLOBAL_DIM_EN
   logic [7:0]  dim;
`endif

   logic [15:0] ram1 [256];
   logic [15:0] ram2 [256];

   int total  = 0;
   int passed = 0;

   typedef struct {
      int edges, r1_ones, r2_ones, r1_first, r1_last;
      int lat_len, lat_clk, oe_shift, oe_len, show_len, strobes, plane_seen;
      int timeout;
   } meas_t;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      rdata_1 <= ram1[raddr];
      rdata_2 <= ram2[raddr];
   end

   icnd2026_bcm_scanner dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_enable       (enable),
`ifdef ICND2026_GLOBAL_DIM_EN
      .i_dim          (dim),
`endif
      .o_raddr        (raddr),
      .i_rdata_1      (rdata_1),
      .i_rdata_2      (rdata_2),
      .o_led_clk      (led_clk),
      .o_led_lat      (led_lat),
      .o_led_oe       (led_oe),
      .o_led_red1     (red1),
      .o_led_red2     (red2),
      .o_frame_strobe (frame_strobe),
      .o_plane        (plane)
   );

   task automatic fill_rams(input logic [15:0] v1, input logic [15:0] v2);
      for (int i = 0; i < 256; i++) begin
         ram1[i] = v1;
         ram2[i] = v2;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Follows one plane from FETCH/IDLE through SHOW, sampling on falling edges
   task automatic measure_plane(output meas_t m);
      int cyc;
      bit prev_clk;
      m = '{default: 0};
      cyc = 0;
      prev_clk = 1'b0;
      do begin
         @(negedge clk);
         cyc++;
         if (led_clk && !prev_clk) begin
            if (m.edges == 0) m.r1_first = int'(red1);
            m.r1_last = int'(red1);
            m.edges++;
            if (red1) m.r1_ones++;
            if (red2) m.r2_ones++;
         end
         prev_clk = led_clk;
         if (!led_oe) m.oe_shift++;
         if (frame_strobe) m.strobes++;
         m.plane_seen = int'(plane);
      end while (!led_lat && cyc < LIMIT);
      m.lat_len = 1;
      if (led_clk) m.lat_clk++;
      while (led_lat && cyc < LIMIT) begin
         @(negedge clk);
         cyc++;
         if (led_lat) begin
            m.lat_len++;
            if (led_clk) m.lat_clk++;
         end
      end
      while (!(raddr == 8'hFF || (led_oe && !enable && m.oe_len > 0)) && cyc < LIMIT) begin
         m.show_len++;
         if (!led_oe) m.oe_len++;
         if (frame_strobe) m.strobes++;
         @(negedge clk);
         cyc++;
      end
      if (frame_strobe) m.strobes++;
      m.timeout = (cyc >= LIMIT) ? 1 : 0;
   endtask

   task automatic test_reset();
      int clk_hi;
      enable = 1'b0;
      do_reset();
      @(negedge clk);
      total++; if (led_oe !== 1'b1) $display("FAIL reset_oe got %b want 1", led_oe); else passed++;
      total++; if (led_clk !== 1'b0) $display("FAIL reset_clk got %b want 0", led_clk); else passed++;
      total++; if (led_lat !== 1'b0) $display("FAIL reset_lat got %b want 0", led_lat); else passed++;
      total++; if (raddr !== 8'd0) $display("FAIL reset_raddr got %0d want 0", raddr); else passed++;
      total++; if ({red1, red2} !== 2'b00) $display("FAIL reset_data got %b want 00", {red1, red2}); else passed++;
      total++; if (frame_strobe !== 1'b0) $display("FAIL reset_strobe got %b want 0", frame_strobe); else passed++;
      total++; if (plane !== 3'd0) $display("FAIL reset_plane got %0d want 0", plane); else passed++;
      clk_hi = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (led_clk || !led_oe || led_lat) clk_hi++;
      end
      total++; if (clk_hi !== 0) $display("FAIL idle_quiet got %0d active cycles want 0", clk_hi); else passed++;
   endtask

   task automatic test_planes();
      meas_t m;
      int w;
      fill_rams(16'hFFFF, 16'h0000);
      enable = 1'b1;
      for (int p = 0; p < 8; p++) begin
         measure_plane(m);
         w = 32 << p;
         total++; if (m.timeout !== 0) $display("FAIL planes_timeout plane %0d", p); else passed++;
         total++; if (m.plane_seen !== p) $display("FAIL planes_index got %0d want %0d", m.plane_seen, p); else passed++;
         total++; if (m.edges !== 256) $display("FAIL planes_edges plane %0d got %0d want 256", p, m.edges); else passed++;
         total++; if (m.r1_ones !== 256) $display("FAIL planes_red1 plane %0d got %0d want 256", p, m.r1_ones); else passed++;
         total++; if (m.r2_ones !== 0) $display("FAIL planes_red2 plane %0d got %0d want 0", p, m.r2_ones); else passed++;
         total++; if (m.oe_shift !== 0) $display("FAIL planes_oe_in_shift plane %0d got %0d want 0", p, m.oe_shift); else passed++;
         total++; if (m.lat_len !== 2) $display("FAIL planes_lat_len plane %0d got %0d want 2", p, m.lat_len); else passed++;
         total++; if (m.lat_clk !== 0) $display("FAIL planes_lat_clk plane %0d got %0d want 0", p, m.lat_clk); else passed++;
         total++; if (m.oe_len !== w) $display("FAIL planes_oe_len plane %0d got %0d want %0d", p, m.oe_len, w); else passed++;
         total++; if (m.show_len !== w) $display("FAIL planes_show_len plane %0d got %0d want %0d", p, m.show_len, w); else passed++;
         total++; if (m.strobes !== ((p == 7) ? 1 : 0)) $display("FAIL planes_strobe plane %0d got %0d", p, m.strobes); else passed++;
      end
   endtask

   task automatic test_frame_timing();
      int cyc;
      int n;
      logic after;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!frame_strobe && cyc < LIMIT);
      total++; if (frame_strobe !== 1'b1) $display("FAIL frame_first_strobe got %b want 1", frame_strobe); else passed++;
      n = 0;
      after = 1'b1;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) after = frame_strobe;
      end while (!frame_strobe && n < LIMIT);
      total++; if (after !== 1'b0) $display("FAIL frame_strobe_width got %b want 0", after); else passed++;
      total++; if (n !== 12280) $display("FAIL frame_period got %0d want 12280", n); else passed++;
   endtask

   task automatic test_pattern();
      meas_t m;
      int exp_r1, exp_r2;
      enable = 1'b0;
      do_reset();
      fill_rams(16'h0000, 16'h0100);
      ram1[255] = 16'h8000;
      ram1[0]   = 16'h4000;
      enable = 1'b1;
      for (int p = 0; p < 8; p++) begin
         measure_plane(m);
         exp_r1 = (p >= 6) ? 1 : 0;
         exp_r2 = (p == 0) ? 256 : 0;
         total++; if (m.r1_ones !== exp_r1) $display("FAIL pattern_red1 plane %0d got %0d want %0d", p, m.r1_ones, exp_r1); else passed++;
         total++; if (m.r2_ones !== exp_r2) $display("FAIL pattern_red2 plane %0d got %0d want %0d", p, m.r2_ones, exp_r2); else passed++;
         if (p == 7) begin
            total++; if (m.r1_first !== 1) $display("FAIL pattern_first_edge got %0d want 1", m.r1_first); else passed++;
         end
         if (p == 6) begin
            total++; if (m.r1_last !== 1) $display("FAIL pattern_last_edge got %0d want 1", m.r1_last); else passed++;
         end
      end
   endtask

   task automatic test_enable_drop();
      meas_t m;
      int cyc;
      int active;
      enable = 1'b0;
      do_reset();
      fill_rams(16'hFFFF, 16'h0000);
      enable = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(plane == 3'd3 && led_clk) && cyc < LIMIT);
      total++; if (!(plane == 3'd3 && led_clk)) $display("FAIL drop_reach_plane3 got plane %0d clk %b", plane, led_clk); else passed++;
      enable = 1'b0;
      measure_plane(m);
      total++; if (m.timeout !== 0) $display("FAIL drop_timeout got %0d want 0", m.timeout); else passed++;
      total++; if (m.plane_seen !== 3) $display("FAIL drop_plane got %0d want 3", m.plane_seen); else passed++;
      total++; if (m.lat_len !== 2) $display("FAIL drop_lat_len got %0d want 2", m.lat_len); else passed++;
      total++; if (m.oe_len !== 256) $display("FAIL drop_oe_len got %0d want 256", m.oe_len); else passed++;
      active = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (led_clk || !led_oe || led_lat) active++;
      end
      total++; if (active !== 0) $display("FAIL drop_idle_quiet got %0d active cycles want 0", active); else passed++;
      total++; if (plane !== 3'd4) $display("FAIL drop_plane_after got %0d want 4", plane); else passed++;
      total++; if (raddr !== 8'd0) $display("FAIL drop_raddr got %0d want 0", raddr); else passed++;
   endtask

   task automatic test_reset_mid_show();
      meas_t m;
      int cyc;
      fill_rams(16'hFFFF, 16'h0000);
      enable = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(plane == 3'd2 && !led_oe) && cyc < LIMIT);
      total++; if (!(plane == 3'd2 && !led_oe)) $display("FAIL midrst_reach_show got plane %0d oe %b", plane, led_oe); else passed++;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      total++; if (led_oe !== 1'b1) $display("FAIL midrst_oe got %b want 1", led_oe); else passed++;
      total++; if ({led_clk, led_lat} !== 2'b00) $display("FAIL midrst_clk_lat got %b want 00", {led_clk, led_lat}); else passed++;
      total++; if (raddr !== 8'd0) $display("FAIL midrst_raddr got %0d want 0", raddr); else passed++;
      total++; if (plane !== 3'd0) $display("FAIL midrst_plane got %0d want 0", plane); else passed++;
      @(negedge clk);
      total++; if (raddr !== 8'hFF) $display("FAIL midrst_restart_raddr got %0d want 255", raddr); else passed++;
      measure_plane(m);
      total++; if (m.plane_seen !== 0) $display("FAIL midrst_restart_plane got %0d want 0", m.plane_seen); else passed++;
      total++; if (m.edges !== 256) $display("FAIL midrst_restart_edges got %0d want 256", m.edges); else passed++;
      total++; if (m.oe_len !== 32) $display("FAIL midrst_restart_oe got %0d want 32", m.oe_len); else passed++;
   endtask

`ifdef ICND2026_GLOBAL_DIM_EN
   task automatic test_dim();
      meas_t m;
      enable = 1'b0;
      dim = 8'd127;
      do_reset();
      fill_rams(16'hFFFF, 16'h0000);
      enable = 1'b1;
      for (int p = 0; p < 3; p++) begin
         measure_plane(m);
         total++; if (m.oe_len !== (16 << p)) $display("FAIL dim_oe plane %0d got %0d want %0d", p, m.oe_len, 16 << p); else passed++;
         total++; if (m.show_len !== (32 << p)) $display("FAIL dim_show plane %0d got %0d want %0d", p, m.show_len, 32 << p); else passed++;
      end
      enable = 1'b0;
      dim = 8'd0;
      do_reset();
      enable = 1'b1;
      measure_plane(m);
      total++; if (m.oe_len !== 1) $display("FAIL dim_min_oe got %0d want 1", m.oe_len); else passed++;
      total++; if (m.show_len !== 32) $display("FAIL dim_min_show got %0d want 32", m.show_len); else passed++;
      dim = 8'd255;
   endtask
`endif

   initial begin
      rst_n  = 1'b0;
      enable = 1'b0;
`ifdef ICND2026_GLOBAL_DIM_EN
      dim = 8'd255;
`endif
      fill_rams(16'h0000, 16'h0000);
      test_reset();
      test_planes();
      test_frame_timing();
      test_pattern();
      test_enable_drop();
      test_reset_mid_show();
`ifdef ICND2026_GLOBAL_DIM_EN
      test_dim();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
